// File: rtl/switch_debounce.sv
// switch_debounce: per-channel synchronizer + four-state debounce FSM for active-low DIP switches.
// Edge pulses (sw_rise/sw_fall/any_change) exist only when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce #(
   parameter int WIDTH = 4,
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             any_change
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   // bit 1 of the encoding is the debounced level, bit 0 marks a pending change
   typedef enum logic [1:0] {
      STABLE_OFF = 2'b00,
      PEND_ON    = 2'b01,
      STABLE_ON  = 2'b10,
      PEND_OFF   = 2'b11
   } state_t;
   logic [WIDTH-1:0] sync1, sync2, y, accept;
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= s;
         sync2 <= sync1;
      end
   end
   assign y = ~sync2;
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      state_t state, state_nxt;
      logic [CW-1:0] cnt, cnt_nxt;
      always_ff @(posedge clk) begin
         if (!reset) begin
            state <= STABLE_OFF;
            cnt   <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
         end
      end
      // the cycle that enters PEND already counts as the first differing sample
      always_comb begin
         state_nxt = state;
         cnt_nxt   = '0;
         if (y[i] == state[1])
            state_nxt = state_t'({state[1], 1'b0});
         else if (!state[0]) begin
            state_nxt = state_t'({state[1], 1'b1});
            cnt_nxt   = CW'(1);
         end else if (cnt == LAST)
            state_nxt = state_t'({~state[1], 1'b0});
         else
            cnt_nxt = cnt + 1'b1;
      end
      always_comb accept[i] = state[0] && (y[i] != state[1]) && (cnt == LAST);
      assign sw[i] = state[1];
   end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_rise    <= '0;
         sw_fall    <= '0;
         any_change <= 1'b0;
      end else begin
         sw_rise    <= accept & ~sw;
         sw_fall    <= accept & sw;
         any_change <= |accept;
      end
   end
`else
   assign sw_rise    = '0;
   assign sw_fall    = '0;
   assign any_change = 1'b0;
`endif
endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of independent switch channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120000, the number of consecutive stable clk cycles required to accept a change (5 ms at 24 MHz); legal range 2..2^24.
REQ-003 SHALL have port clk  input  1  rising-edge clock from the 24 MHz on-chip high-frequency oscillator.
REQ-004 SHALL have port reset  input  1  synchronous, active-low.
REQ-005 SHALL have port s  input  WIDTH  raw asynchronous DIP-switch pins, active-low (0 = switch on).
REQ-006 SHALL have port sw  output  WIDTH  debounced switch state, active-high (1 = switch on).
REQ-007 SHALL have port sw_rise  output  WIDTH  one-cycle pulse when sw[i] goes 0->1.
REQ-008 SHALL have port sw_fall  output  WIDTH  one-cycle pulse when sw[i] goes 1->0.
REQ-009 SHALL have port any_change  output  1  OR-reduction of sw_rise and sw_fall.

Function
REQ-010 Each s[i] SHALL pass through a two-flop synchronizer; the second-stage output, inverted, is y[i]; no other logic reads s directly.
REQ-011 Each channel SHALL implement a four-state FSM: STABLE_OFF, PEND_ON, STABLE_ON, PEND_OFF.
REQ-012 STABLE_OFF -> PEND_ON when y[i]=1; STABLE_ON -> PEND_OFF when y[i]=0; otherwise stay.
REQ-013 In PEND_x, the per-channel counter SHALL increment by 1 each cycle y[i] still differs from sw[i].
REQ-014 In PEND_x, if y[i] reverts to equal sw[i], the FSM SHALL return to the prior STABLE state and clear the counter on that edge; sw[i] SHALL not change.
REQ-015 In PEND_x, when the counter equals DEBOUNCE_CYCLES-1 and y[i] still differs, on that edge sw[i] SHALL toggle, the FSM SHALL enter the new STABLE state, and the counter SHALL clear.
REQ-016 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap past DEBOUNCE_CYCLES-1.
REQ-017 Latency: for a clean step on s[i] first captured at edge 1, sw[i] SHALL update at edge DEBOUNCE_CYCLES+2.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on sw, sw_rise or sw_fall.
REQ-019 sw_rise[i]/sw_fall[i] SHALL be registered and assert on the same edge sw[i] updates, for exactly one cycle.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be accepted at their own REQ-017 latency, with any_change high for the shared cycle.

Reset
REQ-021 While reset=0 at a rising edge: synchronizer flops <= all 1 (switches off), sw <= 0, sw_rise <= 0, sw_fall <= 0, any_change <= 0, all FSMs <= STABLE_OFF, all counters <= 0.
REQ-022 Reset asserted mid-PEND SHALL discard pending counts; no edge pulse SHALL be emitted for the aborted transition.
REQ-023 After reset release with a switch held on, sw[i] SHALL rise at edge DEBOUNCE_CYCLES+2 after release, with one sw_rise[i] pulse.

Configuration
REQ-024 Macro SWITCH_DEBOUNCE_EDGE_EN SHALL control edge-pulse generation.
REQ-025 With SWITCH_DEBOUNCE_EDGE_EN defined: sw_rise, sw_fall, any_change behave per REQ-007..009, REQ-019.
REQ-026 Without it: sw_rise, sw_fall, any_change SHALL be tied constant 0, no pulse flops SHALL be inferred, ports remain present, sw behaviour unchanged.

Verification (DEBOUNCE_CYCLES=8, WIDTH=4, macro defined unless stated)
REQ-027 Reset held 3 cycles, s=4'b1111 -> sw=0, sw_rise=sw_fall=0, any_change=0 throughout and after release.
REQ-028 s[0] 1->0 clean step captured at edge 1 -> sw[0]=1 from edge 10, sw_rise[0]=1 for exactly one cycle at edge 10, any_change=1 same cycle.
REQ-029 s[1] pulsed low for 5 cycles then high -> sw[1] stays 0, no pulses; then low for 20 cycles -> sw[1]=1 at edge 10 after capture.
REQ-030 s[2] and s[3] stepped low on same edge, then high 30 cycles later -> sw[3:2]=2'b11 together, later 2'b00 together; sw_fall[3:2]=2'b11 for one cycle.
REQ-031 s[0] low for 6 cycles, reset asserted for 1 cycle, s[0] kept low -> no pulse before reset; sw[0]=1 at edge 10 after release.
REQ-032 Macro undefined, repeat REQ-028 -> sw[0] identical timing; sw_rise, sw_fall, any_change constant 0.
